// File: rtl/rx_pkg.sv
// rx_pkg: types and constants shared by the Rx receive path.
// Build option: RX_PARITY_EN adds the even-parity state to the frame FSM.
package rx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef RX_PARITY_EN
        StParity,
`endif
        StStop
    } rx_state_t;

    // Level of the comparator line when no light frame is in flight.
    localparam logic IDLE_LEVEL = 1'b1;

    localparam int unsigned WORD_COUNT_W = 16;

endpackage

// File: rtl/rx_sync.sv
// rx_sync: two-flop synchronizer for an asynchronous Rx input, plus a
// delayed copy used for falling-edge detection. Resets to the idle level.
module rx_sync
    import rx_pkg::*;
(
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_async,
    output logic o_sync,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronizer chain; reset to the idle level so no false edge appears.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_meta <= IDLE_LEVEL;
            r_sync <= IDLE_LEVEL;
            r_prev <= IDLE_LEVEL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/rx_word_packer.sv
// rx_word_packer: decodes UART-style light frames from the synchronized
// comparator line and packs bytes (byte 0 in the LSBs) into FIFO words.
// Build option: RX_PARITY_EN inserts an even-parity bit after the data bits.
module rx_word_packer
    import rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                    write_clk,
    input  logic                    rstn,
    input  logic                    rx_in,
    input  logic                    fifo_full,
    input  logic                    fifo_wr_success,
    input  logic                    clear_flags,
    output logic [DATA_WIDTH-1:0]   fifo_data,
    output logic                    fifo_write_en,
    output logic                    frame_err,
    output logic                    overflow,
    output logic [WORD_COUNT_W-1:0] word_count
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned TW    = $clog2(CLKS_PER_BIT);
    localparam int unsigned IW    = $clog2(BYTES + 1);

    localparam logic [TW-1:0] MID_TICK = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] END_TICK = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] FULL_IDX = IW'(BYTES);

    logic w_line;
    logic w_fall;

    rx_state_t r_state;
    rx_state_t w_state_next;

    logic [TW-1:0]           r_timer;
    logic [2:0]              r_bit_cnt;
    logic [7:0]              r_shift;
    logic [IW-1:0]           r_byte_idx;
    logic [DATA_WIDTH-1:0]   r_word;
    logic [DATA_WIDTH-1:0]   r_data_hold;
    logic                    r_frame_err;
    logic                    r_overflow;
    logic [WORD_COUNT_W-1:0] r_word_count;

    logic w_tick_mid;
    logic w_tick_end;
    logic w_stop_tick;
    logic w_par_ok;
    logic w_byte_ok;
    logic w_byte_bad;
    logic w_word_done;

    rx_sync u_rx_sync (
        .i_clk   (write_clk),
        .i_rstn  (rstn),
        .i_async (rx_in),
        .o_sync  (w_line),
        .o_fall  (w_fall)
    );

    assign w_tick_mid  = (r_timer == MID_TICK);
    assign w_tick_end  = (r_timer == END_TICK);
    assign w_stop_tick = (r_state == StStop) && w_tick_end;
    assign w_byte_ok   = w_stop_tick && (w_line == IDLE_LEVEL) && w_par_ok;
    assign w_byte_bad  = w_stop_tick && !((w_line == IDLE_LEVEL) && w_par_ok);
    assign w_word_done = (r_byte_idx == FULL_IDX);

    // The full word is presented combinationally in the completion cycle so
    // fifo_full is judged in the same cycle the strobe would assert.
    assign fifo_write_en = w_word_done && !fifo_full;
    assign fifo_data     = w_word_done ? r_word : r_data_hold;
    assign frame_err     = r_frame_err;
    assign overflow      = r_overflow;
    assign word_count    = r_word_count;

`ifdef RX_PARITY_EN
    logic r_par_bad;

    // Even parity: the parity bit must equal the XOR of the data bits.
    always_ff @(posedge write_clk) begin
        if (!rstn) begin
            r_par_bad <= 1'b0;
        end else if ((r_state == StParity) && w_tick_end) begin
            r_par_bad <= (w_line != ^r_shift);
        end
    end

    assign w_par_ok = !r_par_bad;
`else
    assign w_par_ok = 1'b1;
`endif

    // Frame FSM state register.
    always_ff @(posedge write_clk) begin
        if (!rstn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; each state advances only on its bit-timer sample point.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (w_fall) w_state_next = StStart;
            end
            StStart: begin
                // A high line at mid start bit is a glitch, not a frame.
                if (w_tick_mid) w_state_next = (w_line == IDLE_LEVEL) ? StIdle : StData;
            end
            StData: begin
                if (w_tick_end && (r_bit_cnt == 3'd7)) begin
`ifdef RX_PARITY_EN
                    w_state_next = StParity;
`else
                    w_state_next = StStop;
`endif
                end
            end
`ifdef RX_PARITY_EN
            StParity: begin
                if (w_tick_end) w_state_next = StStop;
            end
`endif
            StStop: begin
                if (w_tick_end) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Bit timer and data-bit shifter; timer restarts on every state change.
    always_ff @(posedge write_clk) begin
        if (!rstn) begin
            r_timer   <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            if ((r_state == StIdle) || (w_state_next != r_state) || w_tick_end) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end
            if (r_state == StIdle) begin
                r_bit_cnt <= '0;
            end else if ((r_state == StData) && w_tick_end) begin
                r_shift   <= {w_line, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    // Byte packing; a completed word is either written or dropped next cycle.
    always_ff @(posedge write_clk) begin
        if (!rstn) begin
            r_byte_idx  <= '0;
            r_word      <= '0;
            r_data_hold <= '0;
        end else begin
            if (w_word_done) begin
                r_byte_idx <= '0;
            end else if (w_byte_ok) begin
                for (int unsigned b = 0; b < BYTES; b++) begin
                    if (r_byte_idx == IW'(b)) r_word[8*b +: 8] <= r_shift;
                end
                r_byte_idx <= r_byte_idx + 1'b1;
            end
            if (fifo_write_en) r_data_hold <= r_word;
        end
    end

    // Sticky flags (set wins over clear) and the accepted-write counter.
    always_ff @(posedge write_clk) begin
        if (!rstn) begin
            r_frame_err  <= 1'b0;
            r_overflow   <= 1'b0;
            r_word_count <= '0;
        end else begin
            r_frame_err <= (r_frame_err & ~clear_flags) | w_byte_bad;
            r_overflow  <= (r_overflow & ~clear_flags) | (w_word_done & fifo_full);
            if (fifo_wr_success) r_word_count <= r_word_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_rx_word_packer.sv
// Bench for rx_word_packer: directed scenarios plus a randomized byte stream,
// checked against a byte-queue model of framing and word packing.
`timescale 1ns/1ps
module tb_rx_word_packer;

    localparam int unsigned DW  = 32;
    localparam int unsigned CPB = 16;
    localparam int unsigned NB  = DW / 8;

    logic          write_clk       = 1'b0;
    logic          rstn            = 1'b0;
    logic          rx_in           = 1'b1;
    logic          fifo_full       = 1'b0;
    logic          fifo_wr_success = 1'b0;
    logic          clear_flags     = 1'b0;
    logic [DW-1:0] fifo_data;
    logic          fifo_write_en;
    logic          frame_err;
    logic          overflow;
    logic [15:0]   word_count;

    int            n_vec = 0;
    int            n_err = 0;
    int unsigned   cyc   = 0;
    int unsigned   t_start = 0;
    int unsigned   t_wr    = 0;
    int            lat     = 0;

    logic [DW-1:0] obs_words[$];
    logic [DW-1:0] exp_words[$];
    logic [7:0]    mdl_bytes[$];
    logic [15:0]   exp_wc   = '0;
    logic          exp_ovf  = 1'b0;
    logic          exp_ferr = 1'b0;

    rx_word_packer #(
        .DATA_WIDTH   (DW),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .write_clk       (write_clk),
        .rstn            (rstn),
        .rx_in           (rx_in),
        .fifo_full       (fifo_full),
        .fifo_wr_success (fifo_wr_success),
        .clear_flags     (clear_flags),
        .fifo_data       (fifo_data),
        .fifo_write_en   (fifo_write_en),
        .frame_err       (frame_err),
        .overflow        (overflow),
        .word_count      (word_count)
    );

    always #5 write_clk = ~write_clk;
    always @(posedge write_clk) cyc <= cyc + 1;

    // FIFO stand-in: record each strobe and acknowledge it one cycle later.
    initial begin
        forever begin
            @(negedge write_clk);
            if (fifo_write_en === 1'b1) begin
                obs_words.push_back(fifo_data);
                t_wr = cyc;
                @(posedge write_clk); #1 fifo_wr_success = 1'b1;
                @(posedge write_clk); #1 fifo_wr_success = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish, got running, want finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: good bytes queue up; every NB bytes form a word that is
    // either written (FIFO not full) or dropped with overflow.
    task automatic model_byte(input logic [7:0] b, input bit ok);
        logic [DW-1:0] w;
        if (!ok) begin
            exp_ferr = 1'b1;
            return;
        end
        mdl_bytes.push_back(b);
        if (mdl_bytes.size() == NB) begin
            w = '0;
            for (int i = 0; i < NB; i++) w[8*i +: 8] = mdl_bytes[i];
            if (fifo_full) begin
                exp_ovf = 1'b1;
            end else begin
                exp_words.push_back(w);
                exp_wc++;
            end
            mdl_bytes.delete();
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_bit, input bit par_flip);
        logic [10:0] fb;
        int          nbits;
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[i+1] = b[i];
`ifdef RX_PARITY_EN
        fb[9]  = (^b) ^ par_flip;
        fb[10] = stop_bit;
        nbits  = 11;
`else
        fb[9]  = stop_bit;
        fb[10] = 1'b1;
        nbits  = 10;
`endif
        @(posedge write_clk); #1;
        t_start = cyc;
        for (int i = 0; i < nbits; i++) begin
            rx_in = fb[i];
            repeat (CPB) @(posedge write_clk);
            #1;
        end
        rx_in = 1'b1;
        model_byte(b, stop_bit && !par_flip);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge write_clk);
        #1;
    endtask

    task automatic pulse_clear();
        @(posedge write_clk); #1 clear_flags = 1'b1;
        @(posedge write_clk); #1 clear_flags = 1'b0;
        exp_ferr = 1'b0;
        exp_ovf  = 1'b0;
    endtask

    task automatic check_words(input string tag);
        chk({tag, "_cnt"}, 64'(obs_words.size()), 64'(exp_words.size()));
        for (int i = 0; i < exp_words.size() && i < obs_words.size(); i++)
            chk({tag, "_word"}, 64'(obs_words[i]), 64'(exp_words[i]));
        obs_words.delete();
        exp_words.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge write_clk);
        chk({tag, "_data"}, 64'(fifo_data), 64'h0);
        chk({tag, "_wen"},  64'(fifo_write_en), 64'h0);
        chk({tag, "_ferr"}, 64'(frame_err), 64'h0);
        chk({tag, "_ovf"},  64'(overflow), 64'h0);
        chk({tag, "_wc"},   64'(word_count), 64'h0);
    endtask

    initial begin
        logic [7:0] rb;
        bit         rs;
        int unsigned target;

        // Reset values.
        idle(3);
        check_reset_outputs("rst0");
        rstn = 1'b1;
        idle(5);

        // Four good bytes -> one write of 0x44332211, then word_count = 1.
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        send_frame(8'h33, 1'b1, 1'b0);
        send_frame(8'h44, 1'b1, 1'b0);
        lat = int'(t_wr) - int'(t_start);
        if (lat < 0 || lat > 400) lat = 0;
        idle(4);
        if (obs_words.size() > 0) chk("t1_const", 64'(obs_words[0]), 64'h44332211);
        check_words("t1");
        chk("t1_wc", 64'(word_count), 64'(exp_wc));
        chk("t1_ferr", 64'(frame_err), 64'h0);
        idle(20);
        chk("t1_hold", 64'(fifo_data), 64'h44332211);

        // Short low glitch: no frame, no flags, no write.
        @(posedge write_clk); #1 rx_in = 1'b0;
        idle(CPB / 4);
        rx_in = 1'b1;
        idle(3 * CPB);
        chk("glitch_ferr", 64'(frame_err), 64'h0);
        chk("glitch_ovf", 64'(overflow), 64'h0);
        chk("glitch_nowr", 64'(obs_words.size()), 64'h0);

        // Bad stop bit: byte discarded, index unchanged.
        send_frame(8'h55, 1'b0, 1'b0);
        idle(2);
        chk("t3_ferr", 64'(frame_err), 64'(exp_ferr));
        send_frame(8'hAA, 1'b1, 1'b0);
        chk("t3_hold", 64'(fifo_data), 64'h44332211);
        repeat (3) send_frame(8'hAA, 1'b1, 1'b0);
        idle(4);
        check_words("t3");
        pulse_clear();
        idle(2);
        chk("t3_clr", 64'(frame_err), 64'h0);

        // Full FIFO at completion: word dropped; clear in the same cycle loses.
        send_frame(8'hC1, 1'b1, 1'b0);
        send_frame(8'hC2, 1'b1, 1'b0);
        send_frame(8'hC3, 1'b1, 1'b0);
        fifo_full = 1'b1;
        fork
            send_frame(8'hC4, 1'b1, 1'b0);
            begin
                @(posedge write_clk); #2;
                target = t_start + lat;
                while (cyc < target) begin
                    @(posedge write_clk); #1;
                end
                clear_flags = 1'b1;
                @(posedge write_clk); #1 clear_flags = 1'b0;
            end
        join
        fifo_full = 1'b0;
        idle(4);
        chk("t4_ovf", 64'(overflow), 64'(exp_ovf));
        check_words("t4");
        pulse_clear();
        idle(2);
        chk("t4_clr", 64'(overflow), 64'h0);

        // Mid-frame reset drops the partial word.
        send_frame(8'h5A, 1'b0, 1'b0);
        send_frame(8'hA1, 1'b1, 1'b0);
        send_frame(8'hB2, 1'b1, 1'b0);
        @(posedge write_clk); #1 rx_in = 1'b0;
        idle(40);
        rstn = 1'b0;
        idle(2);
        check_reset_outputs("rst1");
        rx_in = 1'b1;
        mdl_bytes.delete();
        exp_words.delete();
        obs_words.delete();
        exp_wc   = '0;
        exp_ovf  = 1'b0;
        exp_ferr = 1'b0;
        @(posedge write_clk); #1 rstn = 1'b1;
        idle(5);
        send_frame(8'h01, 1'b1, 1'b0);
        send_frame(8'h02, 1'b1, 1'b0);
        send_frame(8'h03, 1'b1, 1'b0);
        send_frame(8'h04, 1'b1, 1'b0);
        idle(4);
        if (obs_words.size() > 0) chk("t5_const", 64'(obs_words[0]), 64'h04030201);
        check_words("t5");

        // Randomized byte stream with occasional bad stop bits.
        for (int i = 0; i < 24; i++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 7) != 0);
            send_frame(rb, rs, 1'b0);
            idle(int'($urandom_range(0, 5)));
        end
        idle(4);
        check_words("rand");
        chk("rand_ferr", 64'(frame_err), 64'(exp_ferr));
        chk("rand_ovf", 64'(overflow), 64'(exp_ovf));
        chk("rand_wc", 64'(word_count), 64'(exp_wc));

`ifdef RX_PARITY_EN
        pulse_clear();
        send_frame(8'h03, 1'b1, 1'b1);
        idle(2);
        chk("par_bad", 64'(frame_err), 64'h1);
        pulse_clear();
        for (int i = 0; i < NB; i++) send_frame(8'h03, 1'b1, 1'b0);
        idle(4);
        chk("par_ok", 64'(frame_err), 64'h0);
        check_words("par");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rx_word_packer.md
# rx_word_packer

Receive-side framing and packing stage feeding the Rx async FIFO's write port. It oversamples the photodiode comparator line on write_clk, decodes UART-style light frames (start, 8 data bits LSB first, stop), and packs consecutive bytes into DATA_WIDTH-bit words. Each completed word is issued as a single-cycle FIFO write, gated by the FIFO full flag. Framing errors and FIFO overflows are reported as sticky flags, and successful writes are counted.

## Interface
- DATA_WIDTH, 32, word width; multiple of 8, ≥ 8; BYTES = DATA_WIDTH/8
- CLKS_PER_BIT, 16, write_clk cycles per bit period; even, ≥ 4
- write_clk  in  1  sample/system clock; all logic on posedge
- rstn  in  1  reset, synchronous, active-low; clock write_clk
- rx_in  in  1  asynchronous comparator output; idle high
- fifo_full  in  1  FIFO full flag (write_clk domain)
- fifo_wr_success  in  1  FIFO write-accepted pulse, one cycle after write
- clear_flags  in  1  clears frame_err and overflow
- fifo_data  out  DATA_WIDTH  packed word; byte 0 in [7:0]
- fifo_write_en  out  1  one-cycle write strobe
- frame_err  out  1  sticky: stop (or parity) bit bad
- overflow  out  1  sticky: word dropped because FIFO full
- word_count  out  16  count of fifo_wr_success pulses; wraps

## Operation
- rx_in passes through a 2-FF synchronizer; a third register provides falling-edge detection. All decoding uses the synchronized value.
- FSM states: IDLE, START, DATA, PARITY (only when the macro is defined), STOP.
- IDLE: on a synchronized falling edge, go to START and clear the bit-timer.
- START: at timer = CLKS_PER_BIT/2-1 (mid-bit), sample the line.
  - Low: go to DATA and restart the timer.
  - High: treat as a glitch; return to IDLE with no flag set.
- DATA: sample at every timer = CLKS_PER_BIT-1. Shift into the byte register LSB first. After 8 samples, go to PARITY or STOP.
- STOP: sample at CLKS_PER_BIT-1.
  - High (and parity OK): append the byte at index byte_idx, then byte_idx++.
  - Otherwise: set frame_err, discard the byte, leave byte_idx unchanged.
  - Both cases return to IDLE.
- Word complete (byte_idx reaches BYTES):
  - Next cycle, if fifo_full = 0: fifo_write_en = 1 for exactly one cycle, with fifo_data holding the word.
  - If fifo_full = 1: no write; set overflow; discard the word.
  - byte_idx returns to 0 in either case.
- A partial word is held indefinitely. There is no timeout flush; it is cleared only by rstn.
- word_count increments on each fifo_wr_success and wraps 65535 → 0.
- clear_flags clears frame_err and overflow. If a set event occurs in the same cycle, the set wins.

## Timing
- Reset values: fifo_data = 0, fifo_write_en = 0, frame_err = 0, overflow = 0, word_count = 0. FSM = IDLE, byte_idx = 0, synchronizer registers = 1.
- rstn asserted mid-frame aborts the frame on the next edge; the partial word is lost.
- Line-to-decoder latency: 2 cycles (synchronizer).
- Latency from the last stop-bit sample to fifo_write_en: 1 cycle. fifo_data is stable in that cycle and holds until the next write.
- fifo_full is sampled in the same cycle fifo_write_en would assert. The FIFO's registered full lags one write, so a write issued on its last free slot is accepted by the FIFO.
- Minimum spacing between writes is BYTES × frame length, so back-to-back strobes never occur.
- A new start edge is accepted from the first IDLE cycle after STOP.

## Configuration
- RX_PARITY_EN defined:
  - A PARITY state follows DATA and samples one even-parity bit.
  - Frame length is 11 bits.
  - A mismatch sets frame_err and discards the byte, exactly like a bad stop bit.
- RX_PARITY_EN undefined:
  - The PARITY state and its logic are absent.
  - Frame length is 10 bits.

## Structure
- Shared package rx_pkg holds:
  - the FSM state enum (rx_state_t);
  - the idle line level constant;
  - the word_count width constant (16).
- One natural sub-module: rx_sync, the 2-FF synchronizer plus edge detect. It is reused for other asynchronous Rx inputs.
- The bit-timer width is $clog2(CLKS_PER_BIT); the byte_idx width is $clog2(BYTES+1).

## Test plan
- Bytes 0x11, 0x22, 0x33, 0x44 sent with fifo_full = 0 → one fifo_write_en, fifo_data = 0x44332211. After fifo_wr_success, word_count = 1.
- Low glitch of CLKS_PER_BIT/4 cycles on an idle line → FSM returns to IDLE; no flags set, no write.
- Byte 0x55 with stop bit low, then 0xAA ×4 → frame_err = 1; the next word is 0xAAAAAAAA (bad byte discarded, index unchanged).
- Four bytes sent with fifo_full = 1 at the completion cycle → no write, overflow = 1. clear_flags asserted in the same cycle as a new overflow → overflow stays 1.
- rstn asserted after 2 of 4 bytes, then 0x01..0x04 sent → fifo_data = 0x04030201 (no stale bytes). All outputs read their reset values during reset.
- RX_PARITY_EN defined, 0x03 sent with parity bit 1 → frame_err = 1, byte discarded. With parity bit 0 → byte accepted.
